// File: rtl/uwire_pkg.sv
// Shared definitions for the uWire arbiter: serializer word type and sequencer state encoding.
package uwire_pkg;

    localparam int UWIRE_WORD_W = 32;

    typedef logic [UWIRE_WORD_W-1:0] uwire_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_DONE
    } uwire_state_t;

endpackage

// File: rtl/uwire_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping around.
module uwire_rr_arbiter
    import uwire_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      rr_ptr,
    output logic               valid,
    output logic [GW-1:0]      winner
);

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return GW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest request to rr_ptr wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                valid  = 1'b1;
                winner = wrap_idx(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/uwire_arbiter.sv
// Shares one uWire serializer between NUM_REQ requesters, sending each granted frame MSW first.
// Optional serializer timeout with err pulses is built when UWIRE_ARB_TIMEOUT_EN is defined.
module uwire_arbiter
    import uwire_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_WORDS      = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [NUM_REQ-1:0]                                 req,
    input  logic [NUM_REQ-1:0][NUM_WORDS-1:0][UWIRE_WORD_W-1:0] d,
    output logic [NUM_REQ-1:0]                                 ack,
    output logic [NUM_REQ-1:0]                                 err,
    output logic                                               busy,
    output logic [GW-1:0]                                      grant_id,
    input  logic                                               tx_ready,
    output logic                                               tx_start,
    output logic [UWIRE_WORD_W-1:0]                            tx_q
);

    localparam int WLW = $clog2(NUM_WORDS + 1);
    localparam int WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef uwire_word_t [NUM_WORDS-1:0] frame_t;

    uwire_state_t       state_reg, state_next;
    frame_t             frame_reg, frame_next;
    logic [WLW-1:0]     words_left_reg, words_left_next;
    logic [GW-1:0]      grant_reg, grant_next;
    logic [GW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic               busy_reg, busy_next;
    logic               tx_start_reg, tx_start_next;
    uwire_word_t        tx_q_reg, tx_q_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;

    logic               arb_valid;
    logic [GW-1:0]      arb_winner;
    logic [GW-1:0]      ptr_after_grant;
    logic [WIW-1:0]     word_sel;

`ifdef UWIRE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      timer_reg, timer_next;
    logic [NUM_REQ-1:0] err_reg, err_next;
    logic               in_wait;
    assign in_wait = (state_reg == ST_WAIT_LOW) || (state_reg == ST_WAIT_HIGH);
`endif

    uwire_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .valid   (arb_valid),
        .winner  (arb_winner)
    );

    assign ptr_after_grant = (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
    assign word_sel        = WIW'(words_left_reg - 1'b1);

    always_comb begin
        state_next      = state_reg;
        frame_next      = frame_reg;
        words_left_next = words_left_reg;
        grant_next      = grant_reg;
        rr_ptr_next     = rr_ptr_reg;
        busy_next       = busy_reg;
        tx_start_next   = 1'b0;
        tx_q_next       = tx_q_reg;
        ack_next        = '0;
`ifdef UWIRE_ARB_TIMEOUT_EN
        err_next        = '0;
        timer_next      = '0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    frame_next      = d[arb_winner];
                    grant_next      = arb_winner;
                    busy_next       = 1'b1;
                    words_left_next = WLW'(NUM_WORDS);
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tx_ready) begin
                    tx_start_next   = 1'b1;
                    tx_q_next       = frame_reg[word_sel];
                    words_left_next = words_left_reg - 1'b1;
                    state_next      = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                // Ready falling is the serializer's acknowledgement that it took the word.
                if (!tx_ready) begin
                    state_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (tx_ready) begin
                    if (words_left_reg != '0) begin
                        tx_start_next   = 1'b1;
                        tx_q_next       = frame_reg[word_sel];
                        words_left_next = words_left_reg - 1'b1;
                        state_next      = ST_WAIT_LOW;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ack_next[grant_reg] = 1'b1;
                busy_next           = 1'b0;
                rr_ptr_next         = ptr_after_grant;
                state_next          = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
`ifdef UWIRE_ARB_TIMEOUT_EN
        // Counter restarts on every state change; a stall of TIMEOUT_CYCLES abandons the frame.
        if (in_wait && (state_next == state_reg)) begin
            if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                err_next[grant_reg] = 1'b1;
                busy_next           = 1'b0;
                rr_ptr_next         = ptr_after_grant;
                state_next          = ST_IDLE;
            end else begin
                timer_next = timer_reg + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            frame_reg      <= '0;
            words_left_reg <= '0;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            busy_reg       <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_q_reg       <= '0;
            ack_reg        <= '0;
`ifdef UWIRE_ARB_TIMEOUT_EN
            timer_reg      <= '0;
            err_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            frame_reg      <= frame_next;
            words_left_reg <= words_left_next;
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            busy_reg       <= busy_next;
            tx_start_reg   <= tx_start_next;
            tx_q_reg       <= tx_q_next;
            ack_reg        <= ack_next;
`ifdef UWIRE_ARB_TIMEOUT_EN
            timer_reg      <= timer_next;
            err_reg        <= err_next;
`endif
        end
    end

    assign ack      = ack_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;
    assign tx_start = tx_start_reg;
    assign tx_q     = tx_q_reg;
`ifdef UWIRE_ARB_TIMEOUT_EN
    assign err      = err_reg;
`else
    assign err      = '0;
`endif

endmodule
